uart_mm_peripheral: RTL and testbench
=====================================

# uart_mm_peripheral

Memory-mapped 8N1 UART peripheral for the RISC-V multi-cycle SoC. It sits beside RAM and GPIO on the memory map controller's slave side, consuming core load/store traffic decoded to the UART window. It drives the serial `tx` line and samples the serial `rx` line. It exposes TX data, RX data and status registers, plus a level interrupt for received data.

## Interface
Parameters:
- `DATA_WIDTH`, 32, bus data width.
- `CLK_FREQ`, 50_000_000, clock frequency in Hz.
- `BAUD`, 115200, line rate. `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division, must be ≥ 4).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-low.
- `we`  in  1  write strobe from the memory map controller.
- `re`  in  1  read strobe from the memory map controller.
- `A`  in  4  byte offset within the UART window; only `A[3:2]` is decoded.
- `WD`  in  DATA_WIDTH  write data; only `WD[7:0]` is used.
- `RD`  out  DATA_WIDTH  read data, combinational.
- `rx`  in  1  serial input, asynchronous to `clk`.
- `tx`  out  1  serial output; idle high.
- `irq`  out  1  equals `rx_valid`.

## Operation
Register map, selected by `A[3:2]`:
- 0 TXDATA (W): write loads `WD[7:0]` and starts a frame if `tx_busy`=0. A write while busy is ignored. Reads return 0.
- 1 RXDATA (R): returns `{24'h0, rx_data}`. A read with `re`=1 clears `rx_valid` at the next edge.
- 2 STATUS (R): returns `{28'h0, frame_err, overrun, rx_valid, tx_busy}`. A read with `re`=1 clears `overrun` and `frame_err`.
- 3: reserved; reads 0, writes ignored.
- `RD` = 0 whenever `re`=0.

TX FSM (`TX_IDLE` → `TX_START` → `TX_DATA` → `TX_STOP` → `TX_IDLE`):
- Each state holds for `CLKS_PER_BIT` cycles, timed by the bit counter.
- `TX_START` drives 0. `TX_DATA` drives bits 0..7, LSB first, using a 3-bit index. `TX_STOP` drives 1.
- `tx_busy` = (state ≠ `TX_IDLE`).

RX path:
- `rx` passes through a 2-flop synchronizer; both flops reset to 1.
- `RX_IDLE`: on a synchronized falling edge, go to `RX_START` and load the counter with `CLKS_PER_BIT/2`.
- `RX_START`: at mid-bit, a 0 goes to `RX_DATA`. A 1 is a glitch: return to `RX_IDLE` with no flags set.
- `RX_DATA`: sample 8 bits at mid-bit spacing of `CLKS_PER_BIT`, LSB first, into a shift register.
- `RX_STOP`, at mid-bit:
  - Stop bit = 1: load `rx_data`, set `rx_valid`. If `rx_valid` was already 1 and is not being cleared this cycle, also set `overrun`. The new byte overwrites the old one.
  - Stop bit = 0: discard the byte, set `frame_err`, leave `rx_valid` unchanged.
- Return to `RX_IDLE`.

Simultaneous events:
- RX completion in the same cycle as a RXDATA read: `rx_valid` stays 1, `overrun` stays 0, and `rx_data` takes the new byte. The read itself returns the old byte.
- A flag set in the same cycle as a STATUS read: the set wins.
- TXDATA write in the final stop-bit cycle: ignored, because the block is still busy.

## Timing
- Reset values: `tx`=1, `irq`=0, `RD`=0. All flags are 0, `rx_data`=0, and both FSMs are idle.
- Reset asserted mid-frame aborts immediately: `tx`=1 asynchronously.
- TX latency: the write edge moves the FSM to `TX_START`, so `tx` falls in the cycle after the write.
- A frame occupies exactly 10·`CLKS_PER_BIT` cycles. `tx_busy` drops in the cycle after the last stop-bit cycle.
- RX: `rx_valid` rises at the stop-bit mid-sample. Synchronizer delay is 2 cycles.
- Register writes and flag clears take effect at the rising `clk` edge in which the strobe is high.

## Structure
- Package `uart_pkg`:
  - `tx_fsm_state_t` and `rx_fsm_state_t` enums.
  - Register index constants `UART_TXDATA`=0, `UART_RXDATA`=1, `UART_STATUS`=2.
  - Status bit positions.
- Sub-module `uart_bit_timer`: a loadable down-counter with a `tick` output at 0, instantiated once for TX and once for RX.
- The top level contains the register file, both FSMs and the synchronizer.

## Test plan
Bench uses `CLK_FREQ`=1_000_000 and `BAUD`=100_000, so `CLKS_PER_BIT`=10.
- Reset, then write TXDATA=0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,1, each bit held 10 cycles. `tx_busy`=1 for exactly 100 cycles.
- Write 0x11 during a frame → the write is ignored, and the frame in progress completes with its original byte.
- Drive 0x3C onto `rx` at 10 cycles/bit → `rx_valid`=1 and `irq`=1. RXDATA read returns 0x3C, then `rx_valid`=0.
- Send 0x01 then 0x02 with no read in between → RXDATA=0x02. STATUS=0x6, i.e. `overrun`=1 and `rx_valid`=1. A second STATUS read returns 0x2.
- Send a frame with stop bit 0 → `frame_err`=1, `rx_valid` unchanged. A 3-cycle low glitch on `rx` → no flags set.
- Assert `rst` low mid-TX → `tx`=1 immediately. STATUS reads 0 after reset is released.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped 8N1 UART.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_fsm_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_fsm_state_t;

    // Register indices, decoded from A[3:2]
    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_RXDATA = 2'd1;
    localparam logic [1:0] UART_STATUS = 2'd2;

    // STATUS register bit positions
    localparam int STAT_TX_BUSY   = 0;
    localparam int STAT_RX_VALID  = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tick is high while the count sits at zero.
module uart_bit_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    output logic             tick
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= CNT_ZERO;
        end else if (load) begin
            count_r <= loadValue;
        end else if (count_r != CNT_ZERO) begin
            count_r <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign tick = (count_r == CNT_ZERO);

endmodule

// File: rtl/uart_mm_peripheral.sv
// Memory-mapped 8N1 UART: TX/RX data and status registers, level irq on rx_valid.
module uart_mm_peripheral
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [3:0]            A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    input  logic                  rx,
    output logic                  tx,
    output logic                  irq
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2);

    logic [1:0]            regSel_s;
    logic                  unusedBits_s;
    logic [DATA_WIDTH-1:0] rdData_s;

    tx_fsm_state_t txState_r;
    logic          txOut_r;
    logic [7:0]    txByte_r;
    logic [2:0]    txBitIdx_r;
    logic          txBusy_s, txStart_s, txLoad_s, txTick_s;

    rx_fsm_state_t rxState_r;
    logic          rxSync1_r, rxSync2_r, rxPrev_r;
    logic [7:0]    rxShift_r, rxData_r;
    logic [2:0]    rxBitIdx_r;
    logic          rxValid_r, overrun_r, frameErr_r;
    logic          rxFallEdge_s, rxTick_s, rxLoad_s, rxDone_s, rxFrameErr_s;
    logic          rxReadClr_s, statusReadClr_s;
    logic [CNT_W-1:0] rxLoadVal_s;

    assign regSel_s     = A[3:2];
    assign unusedBits_s = ^{A[1:0], WD[DATA_WIDTH-1:8]};

    assign txBusy_s  = (txState_r != TX_IDLE);
    assign txStart_s = we && (regSel_s == UART_TXDATA) && !txBusy_s;
    // Bit timer restarts on frame start and at every bit boundary
    assign txLoad_s  = txStart_s || (txBusy_s && txTick_s);

    uart_bit_timer #(.CNT_W(CNT_W)) txTimer (
        .clk       (clk),
        .rst       (rst),
        .load      (txLoad_s),
        .loadValue (FULL_LOAD),
        .tick      (txTick_s)
    );

    // TX frame sequencer; the line output is registered so reset forces it high at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txState_r  <= TX_IDLE;
            txOut_r    <= 1'b1;
            txByte_r   <= 8'h00;
            txBitIdx_r <= 3'd0;
        end else begin
            case (txState_r)
                TX_IDLE: begin
                    if (txStart_s) begin
                        txState_r  <= TX_START;
                        txOut_r    <= 1'b0;
                        txByte_r   <= WD[7:0];
                        txBitIdx_r <= 3'd0;
                    end
                end
                TX_START: begin
                    if (txTick_s) begin
                        txState_r  <= TX_DATA;
                        txOut_r    <= txByte_r[0];
                        txBitIdx_r <= 3'd0;
                    end
                end
                TX_DATA: begin
                    if (txTick_s) begin
                        if (txBitIdx_r == 3'd7) begin
                            txState_r <= TX_STOP;
                            txOut_r   <= 1'b1;
                        end else begin
                            txBitIdx_r <= txBitIdx_r + 3'd1;
                            txOut_r    <= txByte_r[txBitIdx_r + 3'd1];
                        end
                    end
                end
                TX_STOP: begin
                    if (txTick_s) begin
                        txState_r <= TX_IDLE;
                        txOut_r   <= 1'b1;
                    end
                end
                default: begin
                    txState_r <= TX_IDLE;
                    txOut_r   <= 1'b1;
                end
            endcase
        end
    end

    assign tx = txOut_r;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxSync1_r <= 1'b1;
            rxSync2_r <= 1'b1;
            rxPrev_r  <= 1'b1;
        end else begin
            rxSync1_r <= rx;
            rxSync2_r <= rxSync1_r;
            rxPrev_r  <= rxSync2_r;
        end
    end

    assign rxFallEdge_s = rxPrev_r && !rxSync2_r;

    // Half a bit to reach mid-start, then whole bits between samples
    always_comb begin
        rxLoad_s    = 1'b0;
        rxLoadVal_s = FULL_LOAD;
        if (rxState_r == RX_IDLE) begin
            rxLoad_s    = rxFallEdge_s;
            rxLoadVal_s = HALF_LOAD;
        end else begin
            rxLoad_s    = rxTick_s;
            rxLoadVal_s = FULL_LOAD;
        end
    end

    uart_bit_timer #(.CNT_W(CNT_W)) rxTimer (
        .clk       (clk),
        .rst       (rst),
        .load      (rxLoad_s),
        .loadValue (rxLoadVal_s),
        .tick      (rxTick_s)
    );

    // RX frame sequencer sampling at mid-bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxState_r  <= RX_IDLE;
            rxShift_r  <= 8'h00;
            rxBitIdx_r <= 3'd0;
        end else begin
            case (rxState_r)
                RX_IDLE: begin
                    if (rxFallEdge_s) begin
                        rxState_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (rxTick_s) begin
                        rxBitIdx_r <= 3'd0;
                        rxState_r  <= rxSync2_r ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rxTick_s) begin
                        rxShift_r <= {rxSync2_r, rxShift_r[7:1]};
                        if (rxBitIdx_r == 3'd7) begin
                            rxState_r <= RX_STOP;
                        end else begin
                            rxBitIdx_r <= rxBitIdx_r + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rxTick_s) begin
                        rxState_r <= RX_IDLE;
                    end
                end
                default: rxState_r <= RX_IDLE;
            endcase
        end
    end

    assign rxDone_s        = (rxState_r == RX_STOP) && rxTick_s && rxSync2_r;
    assign rxFrameErr_s    = (rxState_r == RX_STOP) && rxTick_s && !rxSync2_r;
    assign rxReadClr_s     = re && (regSel_s == UART_RXDATA);
    assign statusReadClr_s = re && (regSel_s == UART_STATUS);

    // Received byte and flags; a new event wins over a same-cycle clearing read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxData_r   <= 8'h00;
            rxValid_r  <= 1'b0;
            overrun_r  <= 1'b0;
            frameErr_r <= 1'b0;
        end else begin
            if (rxDone_s) begin
                rxData_r <= rxShift_r;
            end
            if (rxDone_s) begin
                rxValid_r <= 1'b1;
            end else if (rxReadClr_s) begin
                rxValid_r <= 1'b0;
            end
            if (rxDone_s && rxValid_r && !rxReadClr_s) begin
                overrun_r <= 1'b1;
            end else if (statusReadClr_s) begin
                overrun_r <= 1'b0;
            end
            if (rxFrameErr_s) begin
                frameErr_r <= 1'b1;
            end else if (statusReadClr_s) begin
                frameErr_r <= 1'b0;
            end
        end
    end

    // Read mux; returns zero unless a read strobe is present
    always_comb begin
        rdData_s = {DATA_WIDTH{1'b0}};
        if (re) begin
            case (regSel_s)
                UART_RXDATA: rdData_s[7:0] = rxData_r;
                UART_STATUS: begin
                    rdData_s[STAT_TX_BUSY]   = txBusy_s;
                    rdData_s[STAT_RX_VALID]  = rxValid_r;
                    rdData_s[STAT_OVERRUN]   = overrun_r;
                    rdData_s[STAT_FRAME_ERR] = frameErr_r;
                end
                default: rdData_s = {DATA_WIDTH{1'b0}};
            endcase
        end else begin
            rdData_s = {DATA_WIDTH{1'b0}};
        end
    end

    assign RD  = rdData_s;
    assign irq = rxValid_r;

endmodule

// File: tb/tb_uart_mm_peripheral.sv
// Directed bench for uart_mm_peripheral at 10 clocks per bit.
module tb_uart_mm_peripheral;

    logic        clk = 1'b0;
    logic        rst, we, re, rx, tx, irq;
    logic [3:0]  A;
    logic [31:0] WD, RD;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        string       name;
        logic        we;
        logic        re;
        logic [3:0]  addr;
        logic [7:0]  wd;
        logic [31:0] expRd;
        logic        expTx;
        logic        expIrq;
    } vec_t;

    vec_t vecs[10];

    uart_mm_peripheral #(
        .DATA_WIDTH (32),
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .re  (re),
        .A   (A),
        .WD  (WD),
        .RD  (RD),
        .rx  (rx),
        .tx  (tx),
        .irq (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idleBus();
        we = 1'b0; re = 1'b0; A = 4'h0; WD = 32'h0;
    endtask

    task automatic checkRead(input string name, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        @(posedge clk); #1;
        we = 1'b0; re = 1'b1; A = addr;
        @(negedge clk);
        d = RD;
        @(posedge clk); #1;
        re = 1'b0; A = 4'h0;
        check(name, d, exp);
    endtask

    // Drives one 8N1 frame on rx at 10 clocks per bit
    task automatic sendRx(input logic [7:0] b, input logic stopBit);
        logic [9:0] frame;
        frame = {stopBit, b, 1'b0};
        repeat (2) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            #1 rx = frame[i];
            repeat (10) @(posedge clk);
        end
        #1 rx = 1'b1;
    endtask

    task automatic waitIrq(input string name);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'h0, irq}, 32'h1);
    endtask

    // Sends byte b, checks tx every cycle; optional ignored writes of 0x11 at midW and cycle 99
    task automatic txFrameCheck(input logic [7:0] b, input int midW, input logic lastW);
        logic [9:0] frame;
        logic       writing;
        logic       expTx;
        frame = {1'b1, b, 1'b0};
        @(posedge clk); #1;
        we = 1'b1; re = 1'b0; A = 4'h0; WD = {24'h0, b};
        @(posedge clk); #1;
        we = 1'b0; re = 1'b1; A = 4'h8; WD = 32'h0;
        writing = 1'b0;
        for (int k = 0; k < 115; k++) begin
            @(negedge clk);
            expTx = (k < 100) ? frame[k / 10] : 1'b1;
            check($sformatf("tx_bit_c%0d", k), {31'h0, tx}, {31'h0, expTx});
            if (!writing) begin
                check($sformatf("tx_busy_c%0d", k), RD, (k < 100) ? 32'h1 : 32'h0);
            end
            @(posedge clk); #1;
            writing = ((k + 1) == midW) || (lastW && ((k + 1) == 99));
            if (writing) begin
                we = 1'b1; re = 1'b0; A = 4'h0; WD = 32'h11;
            end else begin
                we = 1'b0; re = 1'b1; A = 4'h8; WD = 32'h0;
            end
        end
        idleBus();
    endtask

    initial begin
        // name, we, re, addr, wd, expRd, expTx, expIrq -- applied with rx_valid=1, rx_data=0x3C
        vecs[0] = '{"rd_gated",      1'b0, 1'b0, 4'h4, 8'h00, 32'h00, 1'b1, 1'b1};
        vecs[1] = '{"txdata_reads0", 1'b0, 1'b1, 4'h0, 8'h00, 32'h00, 1'b1, 1'b1};
        vecs[2] = '{"reserved_rd",   1'b0, 1'b1, 4'hC, 8'h00, 32'h00, 1'b1, 1'b1};
        vecs[3] = '{"status_valid",  1'b0, 1'b1, 4'h8, 8'h00, 32'h02, 1'b1, 1'b1};
        vecs[4] = '{"reserved_wr",   1'b1, 1'b0, 4'hC, 8'h5A, 32'h00, 1'b1, 1'b1};
        vecs[5] = '{"no_tx_start",   1'b0, 1'b1, 4'h8, 8'h00, 32'h02, 1'b1, 1'b1};
        vecs[6] = '{"rxdata_wr_ign", 1'b1, 1'b0, 4'h4, 8'hFF, 32'h00, 1'b1, 1'b1};
        vecs[7] = '{"rxdata_rd",     1'b0, 1'b1, 4'h5, 8'h00, 32'h3C, 1'b1, 1'b1};
        vecs[8] = '{"status_clr",    1'b0, 1'b1, 4'h8, 8'h00, 32'h00, 1'b1, 1'b0};
        vecs[9] = '{"rxdata_kept",   1'b0, 1'b1, 4'h4, 8'h00, 32'h3C, 1'b1, 1'b0};

        rst = 1'b0;
        rx  = 1'b1;
        idleBus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx",  {31'h0, tx},  32'h1);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_rd",  RD,           32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        checkRead("rst_status", 4'h8, 32'h0);
        checkRead("rst_rxdata", 4'h4, 32'h0);

        // TX 0xA5, then 0x5A with ignored mid-frame and last-stop-cycle writes
        txFrameCheck(8'hA5, -1, 1'b0);
        txFrameCheck(8'h5A, 35, 1'b1);

        // RX 0x3C followed by the register table
        sendRx(8'h3C, 1'b1);
        waitIrq("rx_3c_irq");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            we = vecs[i].we; re = vecs[i].re; A = vecs[i].addr; WD = {24'h0, vecs[i].wd};
            @(negedge clk);
            check(vecs[i].name, RD, vecs[i].expRd);
            check({vecs[i].name, "_tx"},  {31'h0, tx},  {31'h0, vecs[i].expTx});
            check({vecs[i].name, "_irq"}, {31'h0, irq}, {31'h0, vecs[i].expIrq});
        end
        @(posedge clk); #1;
        idleBus();

        // Overrun: two bytes without a read
        sendRx(8'h01, 1'b1);
        waitIrq("rx_01_irq");
        sendRx(8'h02, 1'b1);
        repeat (5) @(posedge clk);
        checkRead("ovr_status",  4'h8, 32'h6);
        checkRead("ovr_status2", 4'h8, 32'h2);
        checkRead("ovr_rxdata",  4'h4, 32'h02);
        checkRead("ovr_status3", 4'h8, 32'h0);

        // Frame error with rx_valid already set
        sendRx(8'h77, 1'b1);
        waitIrq("rx_77_irq");
        sendRx(8'h99, 1'b0);
        repeat (5) @(posedge clk);
        checkRead("ferr_status",  4'h8, 32'hA);
        checkRead("ferr_status2", 4'h8, 32'h2);
        checkRead("ferr_rxdata",  4'h4, 32'h77);
        checkRead("ferr_status3", 4'h8, 32'h0);

        // Three-cycle low glitch must be rejected
        @(posedge clk); #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("glitch_irq", {31'h0, irq}, 32'h0);
        checkRead("glitch_status", 4'h8, 32'h0);

        // Reset asserted mid-frame forces tx high without a clock edge
        @(posedge clk); #1;
        we = 1'b1; A = 4'h0; WD = 32'h00;
        @(posedge clk); #1;
        idleBus();
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("pre_rst_tx_low", {31'h0, tx}, 32'h0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_tx", {31'h0, tx}, 32'h1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        checkRead("post_rst_status", 4'h8, 32'h0);
        @(negedge clk);
        check("post_rst_tx",  {31'h0, tx},  32'h1);
        check("post_rst_irq", {31'h0, irq}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
